// File: rtl/etm_mul_arbiter.sv
// Round-robin arbiter that shares one fully pipelined ETM multiplier among NREQ
// requesters, tracks requester IDs through a latency-matched tag pipe and returns products.
module etm_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     mul_valid,
  output logic [W-1:0]             mul_a,
  output logic [W-1:0]             mul_b,
  input  logic [2*W-1:0]           mul_result,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [2*W-1:0]           rsp_result,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  // Handshake: requester i transfers on a cycle where req_valid[i] && req_ready[i];
  // it must hold operands stable while valid and not ready, and may drop valid freely.
  // Responses are single-cycle pulses with no backpressure.

  logic [IDW-1:0]  r_rr_ptr;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_grant_id;
  logic            w_xfer;

  logic            r_mul_valid;
  logic [W-1:0]    r_mul_a;
  logic [W-1:0]    r_mul_b;
  logic [IDW-1:0]  r_iss_id;

  logic [LAT-1:0]  r_tag_v;
  logic [IDW-1:0]  r_tag_id [LAT];

  logic [NREQ-1:0] r_rsp_valid;
  logic [2*W-1:0]  r_rsp_result;
  logic [IDW-1:0]  r_rsp_id;

  // Search from r_rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    int              k;
    logic            found;
    logic [IDW-1:0]  idx;
    w_grant    = '0;
    w_grant_id = '0;
    found      = 1'b0;
    k          = 0;
    idx        = '0;
    for (int j = 0; j < NREQ; j++) begin
      k = int'(r_rr_ptr) + j;
      if (k >= NREQ) k = k - NREQ;
      idx = k[IDW-1:0];
      if (en && !found && req_valid[idx]) begin
        found        = 1'b1;
        w_grant[idx] = 1'b1;
        w_grant_id   = idx;
      end
    end
  end

  assign w_xfer    = |w_grant;
  assign req_ready = w_grant;

  // Round-robin pointer and issue stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_mul_valid <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_iss_id    <= '0;
    end else begin
      r_mul_valid <= w_xfer;
      if (w_xfer) begin
        r_rr_ptr <= (w_grant_id == LAST_ID) ? '0 : w_grant_id + IDW'(1);
        r_mul_a  <= req_a[w_grant_id*W +: W];
        r_mul_b  <= req_b[w_grant_id*W +: W];
        r_iss_id <= w_grant_id;
      end
    end
  end

  // Tag pipe mirrors the multiplier pipeline; its last stage lines up with mul_result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      for (int i = 0; i < LAT; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v[0]  <= r_mul_valid;
      r_tag_id[0] <= r_iss_id;
      for (int i = 1; i < LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  // Response register: product passes through untouched at full width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
    end else begin
      if (r_tag_v[LAT-1]) begin
        r_rsp_valid  <= ONE_HOT0 << r_tag_id[LAT-1];
        r_rsp_result <= mul_result;
        r_rsp_id     <= r_tag_id[LAT-1];
      end else begin
        r_rsp_valid  <= '0;
      end
    end
  end

  assign mul_valid  = r_mul_valid;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;
  assign busy       = r_mul_valid | (|r_tag_v) | (|r_rsp_valid);

endmodule

// File: tb/tb_etm_mul_arbiter.sv
// Self-checking bench for etm_mul_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a schedule-based reference model.
module tb_etm_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 2;
  localparam int IDW  = $clog2(NREQ);
  localparam int RS   = 16;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic                mul_valid;
  logic [W-1:0]        mul_a;
  logic [W-1:0]        mul_b;
  logic [2*W-1:0]      mul_result;
  logic [NREQ-1:0]     rsp_valid;
  logic [2*W-1:0]      rsp_result;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  etm_mul_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_id(rsp_id), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- reference model state ----------------
  // Operations are placed on a cycle-indexed schedule: issue one cycle after the
  // handshake, response LAT+2 cycles after it, product taken the cycle before.
  int              m_rr;
  int              m_gnt;
  logic            s_iss_v [RS];
  logic [W-1:0]    s_iss_a [RS];
  logic [W-1:0]    s_iss_b [RS];
  logic            s_rsp_v [RS];
  int              s_rsp_id[RS];
  logic [2*W-1:0]  s_rsp_r [RS];
  logic [W-1:0]    last_a, last_b;
  int              last_id;
  logic [2*W-1:0]  last_res;
  logic [IDW-1:0]  exp_q[$];

  logic [NREQ*W-1:0] drv_a, drv_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_gnt = -1;
    for (int i = 0; i < RS; i++) begin
      s_iss_v[i] = 1'b0; s_iss_a[i] = '0; s_iss_b[i] = '0;
      s_rsp_v[i] = 1'b0; s_rsp_id[i] = 0; s_rsp_r[i] = '0;
    end
    last_a = '0; last_b = '0; last_id = 0; last_res = '0;
    exp_q.delete();
  endtask

  // Compare every DUT output for the current cycle, then advance the model.
  task automatic check_cycle();
    int s, s1, sr, g, k;
    logic eb;
    logic [NREQ-1:0] er;
    s = cyc % RS;
    if (s_rsp_v[s]) begin
      check_eq("rsp_valid", 32'(rsp_valid), 32'(1 << s_rsp_id[s]));
      last_id  = s_rsp_id[s];
      last_res = s_rsp_r[s];
    end else begin
      check_eq("rsp_valid", 32'(rsp_valid), 32'd0);
    end
    check_eq("rsp_id", 32'(rsp_id), 32'(last_id));
    check_eq("rsp_result", 32'(rsp_result), 32'(last_res));
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) check_eq("rsp_spurious", 32'(rsp_valid), 32'd0);
      else check_eq("rsp_order", 32'(rsp_id), 32'(exp_q.pop_front()));
    end
    // busy: some accepted op still has its response due within the next LAT+2 cycles
    eb = 1'b0;
    for (int d = 0; d <= LAT + 1; d++) if (s_rsp_v[(cyc + d) % RS]) eb = 1'b1;
    check_eq("busy", 32'(busy), 32'(eb));
    if (s_iss_v[s]) begin
      last_a = s_iss_a[s];
      last_b = s_iss_b[s];
    end
    check_eq("mul_valid", 32'(mul_valid), 32'(s_iss_v[s]));
    check_eq("mul_a", 32'(mul_a), 32'(last_a));
    check_eq("mul_b", 32'(mul_b), 32'(last_b));
    er = '0;
    g = -1;
    if (en) begin
      for (int j = 0; j < NREQ; j++) begin
        k = (m_rr + j) % NREQ;
        if (g < 0 && req_valid[k]) g = k;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(er));
    m_gnt = -1;
    if (g >= 0 && rst_n) begin
      m_gnt = g;
      m_rr = (g + 1) % NREQ;
      s1 = (cyc + 1) % RS;
      s_iss_v[s1] = 1'b1;
      s_iss_a[s1] = req_a[g*W +: W];
      s_iss_b[s1] = req_b[g*W +: W];
      sr = (cyc + 2 + LAT) % RS;
      s_rsp_v[sr]  = 1'b1;
      s_rsp_id[sr] = g;
      exp_q.push_back(IDW'(g));
    end
    s1 = (cyc + 1) % RS;
    if (s_rsp_v[s1]) s_rsp_r[s1] = mul_result;
    s_iss_v[s] = 1'b0;
    s_rsp_v[s] = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [NREQ-1:0] v, input logic e, input logic [2*W-1:0] mr);
    @(posedge clk);
    #1;
    cyc++;
    req_valid  = v;
    req_a      = drv_a;
    req_b      = drv_b;
    en         = e;
    mul_result = mr;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 16'($urandom_range(0, 65535)));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_mul_valid"}, 32'(mul_valid), 32'd0);
    check_eq({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    check_eq({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check_eq({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NREQ-1:0] cur_v;
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0; mul_result = '0;
    drv_a = '0; drv_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // All requesters continuously valid from reset: grants 0,1,2,3,0,...
    for (int i = 0; i < NREQ; i++) begin
      drv_a[i*W +: W] = 8'(10 + i);
      drv_b[i*W +: W] = 8'(20 + i);
    end
    for (int n = 0; n < 12; n++) begin
      step('1, 1'b1, 16'($urandom_range(0, 65535)));
      check_eq("rr_all_grant", 32'(req_ready), 32'(1 << (n % NREQ)));
      if (n > 0) check_eq("rr_all_mul_valid", 32'(mul_valid), 32'd1);
    end
    idle(6);

    // Single op from requester 2: a=13, b=11, product 143 fed in cycle 3.
    drv_a = '0; drv_b = '0;
    drv_a[2*W +: W] = 8'd13;
    drv_b[2*W +: W] = 8'd11;
    step(4'b0100, 1'b1, 16'd0);
    check_eq("single_ready", 32'(req_ready), 32'b0100);
    step('0, 1'b1, 16'd0);
    check_eq("single_mul_valid", 32'(mul_valid), 32'd1);
    check_eq("single_mul_a", 32'(mul_a), 32'd13);
    check_eq("single_mul_b", 32'(mul_b), 32'd11);
    step('0, 1'b1, 16'd0);
    step('0, 1'b1, 16'd143);
    step('0, 1'b1, 16'd0);
    check_eq("single_rsp_valid", 32'(rsp_valid), 32'b0100);
    check_eq("single_rsp_id", 32'(rsp_id), 32'd2);
    check_eq("single_rsp_result", 32'(rsp_result), 32'd143);
    check_eq("single_busy_hi", 32'(busy), 32'd1);
    step('0, 1'b1, 16'd0);
    check_eq("single_busy_lo", 32'(busy), 32'd0);
    idle(2);

    // Fairness: after a grant to 3, requesters 0 and 3 both valid -> 0 then 3.
    step(4'b1000, 1'b1, 16'($urandom_range(0, 65535)));
    check_eq("fair_g3", 32'(req_ready), 32'b1000);
    step(4'b1001, 1'b1, 16'($urandom_range(0, 65535)));
    check_eq("fair_g0", 32'(req_ready), 32'b0001);
    step(4'b1001, 1'b1, 16'($urandom_range(0, 65535)));
    check_eq("fair_g3b", 32'(req_ready), 32'b1000);
    idle(6);

    // en low blocks grants; one enabled cycle grants exactly rr_ptr (0 here).
    for (int n = 0; n < 4; n++) begin
      step('1, 1'b0, 16'($urandom_range(0, 65535)));
      check_eq("en0_ready", 32'(req_ready), 32'd0);
      check_eq("en0_mul_valid", 32'(mul_valid), 32'd0);
    end
    step('1, 1'b1, 16'($urandom_range(0, 65535)));
    check_eq("en1_grant", 32'(req_ready), 32'b0001);
    for (int n = 0; n < 6; n++) begin
      step('1, 1'b0, 16'($urandom_range(0, 65535)));
      check_eq("en0_after_ready", 32'(req_ready), 32'd0);
    end
    idle(2);

    // Reset with two ops in the tag pipe: no responses, restart from requester 0.
    step(4'b0110, 1'b1, 16'($urandom_range(0, 65535)));
    step(4'b0100, 1'b1, 16'($urandom_range(0, 65535)));
    step('0, 1'b1, 16'($urandom_range(0, 65535)));
    step('0, 1'b1, 16'($urandom_range(0, 65535)));
    check_eq("prerst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    model_reset();
    step('0, 1'b1, 16'($urandom_range(0, 65535)));
    rst_n = 1'b1;
    idle(5);
    step('1, 1'b1, 16'($urandom_range(0, 65535)));
    check_eq("postrst_grant", 32'(req_ready), 32'b0001);
    idle(6);

    // Boundary operands: 255*255 with 16'hFFFF fed back, no truncation.
    drv_a[1*W +: W] = 8'hFF;
    drv_b[1*W +: W] = 8'hFF;
    step(4'b0010, 1'b1, 16'd0);
    check_eq("max_ready", 32'(req_ready), 32'b0010);
    step('0, 1'b1, 16'd0);
    check_eq("max_mul_a", 32'(mul_a), 32'hFF);
    check_eq("max_mul_b", 32'(mul_b), 32'hFF);
    step('0, 1'b1, 16'd0);
    step('0, 1'b1, 16'hFFFF);
    step('0, 1'b1, 16'd0);
    check_eq("max_rsp_valid", 32'(rsp_valid), 32'b0010);
    check_eq("max_rsp_result", 32'(rsp_result), 32'hFFFF);
    idle(3);

    // Randomized traffic: requesters hold operands until granted, sometimes withdraw.
    cur_v = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (cur_v[i] && m_gnt == i) cur_v[i] = 1'b0;
        if (!cur_v[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            cur_v[i] = 1'b1;
            drv_a[i*W +: W] = 8'($urandom_range(0, 255));
            drv_b[i*W +: W] = 8'($urandom_range(0, 255));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          cur_v[i] = 1'b0;
        end
      end
      step(cur_v, ($urandom_range(0, 7) != 0), 16'($urandom_range(0, 65535)));
    end
    idle(8);
    check_eq("final_busy", 32'(busy), 32'd0);
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/etm_mul_arbiter.md
# etm_mul_arbiter

Round-robin arbiter and sequencer that shares one pipelined approximate (ETM) multiplier among NREQ requesters in the CNN datapath. It accepts one operand pair per cycle through valid/ready handshakes and issues it to the multiplier port. It tracks each in-flight operation's requester ID through a tag pipe matched to the multiplier latency. It returns each product to the originating requester as a one-cycle response pulse.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 8, operand width; product width is 2W
- LAT, 2, multiplier latency in cycles from mul_valid to mul_result (>=1)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  grant enable; low blocks new grants, in-flight ops still complete
- req_valid  in  NREQ  per-requester request
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_ready  out  NREQ  one-hot (or zero) grant, combinational
- mul_valid  out  1  issue strobe to multiplier, registered
- mul_a  out  W  operand A to multiplier, registered
- mul_b  out  W  operand B to multiplier, registered
- mul_result  in  2W  multiplier product, valid LAT cycles after mul_valid
- rsp_valid  out  NREQ  one-hot response pulse, registered
- rsp_result  out  2W  product for the pulsing requester, registered
- rsp_id  out  clog2(NREQ)  index of the pulsing requester
- busy  out  1  high while any op is in flight (issue stage, tag pipe or response)

## Operation
- Arbitration: when en=1, req_ready[i]=1 for the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around. All other bits are 0. When en=0 or no request is present, req_ready=0.
- Handshake: a transfer occurs on a cycle where req_valid[i] & req_ready[i] are both high. At most one transfer per cycle. Requesters hold req_a/req_b stable while valid and not ready.
- rr_ptr: after a transfer from requester i, rr_ptr <= (i+1) mod NREQ. It is unchanged on cycles with no transfer.
- Issue stage: on a transfer, the next cycle has mul_valid=1 with mul_a/mul_b = the granted operands. Otherwise mul_valid=0 and mul_a/mul_b hold their last values.
- Tag pipe: LAT-deep shift register of {valid, id}, loaded from the issue stage. It advances every cycle with no stall, since the multiplier is fully pipelined.
- Response: when the tag pipe output is valid, the next cycle has rsp_valid = one-hot(id), rsp_id = id and rsp_result = mul_result as sampled. Otherwise rsp_valid=0 and rsp_id/rsp_result hold.
- Responses have no backpressure. Requesters must consume the one-cycle pulse.
- busy = mul_valid | any tag valid | (rsp_valid != 0).
- The block performs no arithmetic on products. mul_result passes through at full 2W width.

## Timing
- Reset values: mul_valid=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_result=0, rsp_id=0, rr_ptr=0, all tag valid bits=0, busy=0.
- req_ready is combinational from req_valid, en and rr_ptr, and has no registered delay.
- Latency: handshake in cycle 0, then mul_valid in cycle 1, mul_result sampled in cycle 1+LAT, rsp_valid high in cycle 2+LAT. With LAT=2, the response is in cycle 4.
- Throughput: one op per cycle sustained. Response order equals grant order.
- en deasserted mid-stream: no new grants from that cycle. Already-accepted ops still produce responses on schedule, and busy falls the cycle after the last rsp_valid.
- Simultaneous request from all requesters with rr_ptr=k: grants go k, k+1, ..., wrapping, one per cycle. No requester waits more than NREQ-1 cycles while holding valid.
- A requester that drops valid before being granted loses nothing; there is no partial state.
- Async reset mid-operation: all in-flight ops are discarded, no response is emitted for them, and all outputs go to reset values immediately. After rst_n rises, arbitration restarts from rr_ptr=0.

## Test plan
- Single op, LAT=2: requester 2 sends a=13, b=11 in cycle 0. Expect req_ready=4'b0100 in cycle 0, mul_valid with 13/11 in cycle 1, mul_result=143 fed in cycle 3, then rsp_valid=4'b0100, rsp_id=2, rsp_result=143 in cycle 4. busy drops in cycle 5.
- All four requesters continuously valid from reset. Grants go 0,1,2,3,0,1,... one per cycle, and responses return in the same order 4 cycles later with mul_valid held at 1.
- rr_ptr fairness: after a grant to 3, requesters 0 and 3 both valid. The next grant goes to 0, then 3.
- en=0 with all requesters valid: req_ready stays 0 and mul_valid stays 0. Raise en for a single cycle: exactly one grant, to requester rr_ptr.
- Assert rst_n=0 for one cycle while 2 ops are in the tag pipe. Outputs read zero immediately, neither op produces a response, and the first post-reset grant goes to requester 0.
- Boundary operands: a=255, b=255 with mul_result=16'hFFFF fed back. rsp_result=16'hFFFF, with no truncation in the pass-through.
